// File: rtl/mem_port_arbiter_if.sv
// Bundle of port-0, port-1 and shared data-memory signals around mem_port_arbiter.
// slave is the arbiter side; master is the requesters plus the memory.
interface mem_port_arbiter_if;
  logic        p0_req;
  logic        p0_we;
  logic [31:0] p0_addr;
  logic [31:0] p0_wdata;
  logic [1:0]  p0_size;
  logic        p0_gnt;
  logic        p0_rvalid;
  logic [31:0] p0_rdata;

  logic        p1_req;
  logic        p1_we;
  logic        p1_lock;
  logic [31:0] p1_addr;
  logic [31:0] p1_wdata;
  logic [1:0]  p1_size;
  logic        p1_gnt;
  logic        p1_rvalid;
  logic [31:0] p1_rdata;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_size;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_rdata;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata, p0_size,
    output p0_gnt, p0_rvalid, p0_rdata,
    input  p1_req, p1_we, p1_lock, p1_addr, p1_wdata, p1_size,
    output p1_gnt, p1_rvalid, p1_rdata,
    output mem_addr, mem_wdata, mem_size, mem_re, mem_we,
    input  mem_rdata
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata, p0_size,
    input  p0_gnt, p0_rvalid, p0_rdata,
    output p1_req, p1_we, p1_lock, p1_addr, p1_wdata, p1_size,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  mem_addr, mem_wdata, mem_size, mem_re, mem_we,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between the datapath (port 0) and the debug loader (port 1).
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin contention instead of fixed port-0 priority.
//   state | meaning
//   ARB   | normal arbitration between both ports
//   LOCK1 | port 1 owns the memory; port 0 is held off
module mem_port_arbiter #(
  parameter int LOCK_MAX = 4
) (
  input logic               clock,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic {ARB, LOCK1} state_t;

  localparam logic [3:0] LOCK_LAST = 4'(LOCK_MAX);

  state_t     state, state_next;
  logic [3:0] lock_cnt, lock_cnt_next;
  logic       yield, yield_next;
  logic       tag0, tag1;
  logic       gnt0, gnt1;
  logic       contested;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic       rr_p1, rr_p1_next;
`endif

  assign contested = bus.p0_req & bus.p1_req;

  always_comb begin
    gnt0          = 1'b0;
    gnt1          = 1'b0;
    state_next    = state;
    lock_cnt_next = lock_cnt;
    yield_next    = yield;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    rr_p1_next    = rr_p1;
`endif
    // yield: the last lock ran to LOCK_MAX, so port 0 gets the next decision
    if (state == LOCK1) begin
      gnt1 = bus.p1_req;
    end else if (yield) begin
      gnt0 = bus.p0_req;
      gnt1 = bus.p1_req & ~bus.p0_req;
    end else if (contested) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      gnt0 = ~rr_p1;
      gnt1 = rr_p1;
`else
      gnt0 = 1'b1;
`endif
    end else begin
      gnt0 = bus.p0_req;
      gnt1 = bus.p1_req;
    end
    gnt0 = gnt0 & reset;
    gnt1 = gnt1 & reset;

    if (gnt0 | gnt1) yield_next = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (state == ARB && contested && reset) rr_p1_next = gnt0;
`endif
    if (gnt1) begin
      if (state == LOCK1) begin
        if (!bus.p1_lock) begin
          state_next    = ARB;
          lock_cnt_next = 4'd0;
        end else if (lock_cnt + 4'd1 == LOCK_LAST) begin
          state_next    = ARB;
          lock_cnt_next = 4'd0;
          yield_next    = 1'b1;
        end else begin
          lock_cnt_next = lock_cnt + 4'd1;
        end
      end else if (bus.p1_lock && !yield) begin
        if (LOCK_LAST == 4'd1) begin
          yield_next = 1'b1;
        end else begin
          state_next    = LOCK1;
          lock_cnt_next = 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= ARB;
      lock_cnt <= 4'd0;
      yield    <= 1'b0;
      tag0     <= 1'b0;
      tag1     <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_p1    <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      lock_cnt <= lock_cnt_next;
      yield    <= yield_next;
      tag0     <= gnt0 & ~bus.p0_we;
      tag1     <= gnt1 & ~bus.p1_we;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_p1    <= rr_p1_next;
`endif
    end
  end

  assign bus.p0_gnt    = gnt0;
  assign bus.p1_gnt    = gnt1;
  assign bus.mem_we    = (gnt0 & bus.p0_we) | (gnt1 & bus.p1_we);
  assign bus.mem_re    = (gnt0 & ~bus.p0_we) | (gnt1 & ~bus.p1_we);
  assign bus.mem_addr  = gnt0 ? bus.p0_addr  : (gnt1 ? bus.p1_addr  : 32'd0);
  assign bus.mem_wdata = gnt0 ? bus.p0_wdata : (gnt1 ? bus.p1_wdata : 32'd0);
  assign bus.mem_size  = gnt0 ? bus.p0_size  : (gnt1 ? bus.p1_size  : 2'd0);

  assign bus.p0_rvalid = tag0 & reset;
  assign bus.p1_rvalid = tag1 & reset;
  assign bus.p0_rdata  = bus.p0_rvalid ? bus.mem_rdata : 32'd0;
  assign bus.p1_rdata  = bus.p1_rvalid ? bus.mem_rdata : 32'd0;
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter LOCK_MAX, default 4, giving the maximum consecutive locked port-1 transfers (range 1..15).
REQ-002 SHALL have port clock, input, 1, rising-edge clock for all state.
REQ-003 SHALL have port reset, input, 1, synchronous, active-low reset.
REQ-004 SHALL have the port-0 (datapath) inputs: p0_req 1, p0_we 1, p0_addr 32, p0_wdata 32, p0_size 2.
REQ-005 SHALL have the port-0 outputs: p0_gnt 1, p0_rvalid 1, p0_rdata 32.
REQ-006 SHALL have the port-1 (debug loader) inputs: p1_req 1, p1_we 1, p1_lock 1, p1_addr 32, p1_wdata 32, p1_size 2.
REQ-007 SHALL have the port-1 outputs: p1_gnt 1, p1_rvalid 1, p1_rdata 32.
REQ-008 SHALL drive the shared data-memory port: outputs mem_addr 32, mem_wdata 32, mem_size 2, mem_re 1, mem_we 1; input mem_rdata 32.

Function
REQ-009 SHALL complete a transfer in any cycle where pN_req and pN_gnt are both high; at most one gnt high per cycle.
REQ-010 SHALL compute gnt combinationally in the request cycle: zero-wait grant when uncontested.
REQ-011 SHALL, in the grant cycle, drive mem_addr, mem_wdata, mem_size from the granted port, mem_we = pN_we and mem_re = ~pN_we.
REQ-012 SHALL hold mem_re = mem_we = 0 and mem_addr/mem_wdata/mem_size = 0 in cycles with no grant.
REQ-013 SHALL assert pN_rvalid for exactly one cycle, the cycle after a granted read by port N, with pN_rdata = mem_rdata in that cycle; otherwise pN_rdata = 0.
REQ-014 SHALL NOT assert rvalid for writes.
REQ-015 SHALL support back-to-back transfers every cycle, including a read on one port followed by a read on the other; rvalid is routed by a registered port tag.
REQ-016 SHALL implement state machine ARB and LOCK1.
REQ-017 In ARB, when both ports request, SHALL grant per the priority rule (REQ-026/027).
REQ-018 SHALL transition ARB->LOCK1 on a port-1 transfer with p1_lock = 1; lock counter loaded to 1.
REQ-019 In LOCK1, SHALL grant only port 1; p0_gnt = 0 regardless of p0_req.
REQ-020 In LOCK1, each port-1 transfer with p1_lock = 1 SHALL increment the counter; a transfer with p1_lock = 0 SHALL return to ARB.
REQ-021 SHALL, when the counter reaches LOCK_MAX, return to ARB and ignore p1_lock for the next arbitration decision; if p0_req is high in that cycle, port 0 wins.
REQ-022 In LOCK1 with p1_req = 0, SHALL stay in LOCK1 (lock held across idle cycles) and the counter SHALL NOT change.
REQ-023 SHALL require requesters to hold req and all fields stable until granted; behaviour when they do not is undefined.

Reset
REQ-024 SHALL, while reset = 0 at a rising edge, set state ARB, lock counter 0, rvalid tag cleared, round-robin pointer to port 0; all gnt, rvalid, mem_re and mem_we SHALL read 0 while reset is low.
REQ-025 SHALL discard a read issued in the cycle before reset: no rvalid after reset release; a lock active at reset is abandoned.

Configuration
REQ-026 Without macro MEM_ARB_ROUND_ROBIN_EN, SHALL use fixed priority: on contention in ARB, port 0 wins.
REQ-027 With MEM_ARB_ROUND_ROBIN_EN defined, SHALL on contention in ARB grant the port not granted in the most recent contested cycle (pointer starts at port 0 winning); uncontested grants do not move the pointer.

Verification
REQ-028 p0 read addr 0x1000_0010, no p1 -> p0_gnt same cycle, mem_re=1, p0_rvalid next cycle with p0_rdata = mem_rdata.
REQ-029 p0 and p1 requesting continuously, macro off -> p0 granted every cycle, p1_gnt never; macro on -> grants alternate p0,p1,p0,p1.
REQ-030 p1 issues 6 locked writes with LOCK_MAX = 4 while p0_req high -> p1 granted 4 times, p0 granted 5th cycle, then p1 relocks.
REQ-031 p0 read cycle t, p1 read cycle t+1 -> p0_rvalid at t+1, p1_rvalid at t+2, no cross-routing of rdata.
REQ-032 reset low in cycle after granted read and during LOCK1 -> no rvalid, state ARB, p0 granted first cycle after release.
